// File: rtl/tl_pkg.sv
// Shared phase encoding and light decode for the traffic-light intersection controllers.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YLW = 3'd1,
    AR_N   = 3'd2,
    WE_GRN = 3'd3,
    WE_YLW = 3'd4,
    AR_W   = 3'd5
  } phase_e;

  localparam int LT_RED = 0;
  localparam int LT_YLW = 1;
  localparam int LT_GRN = 2;

  // One-hot {grn, ylw, red} for the north approach; anything outside its own phases is red.
  function automatic logic [2:0] nrth_lights(input phase_e s);
    logic [2:0] l;
    l = '0;
    case (s)
      NS_GRN:  l[LT_GRN] = 1'b1;
      NS_YLW:  l[LT_YLW] = 1'b1;
      default: l[LT_RED] = 1'b1;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] west_lights(input phase_e s);
    logic [2:0] l;
    l = '0;
    case (s)
      WE_GRN:  l[LT_GRN] = 1'b1;
      WE_YLW:  l[LT_YLW] = 1'b1;
      default: l[LT_RED] = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ped_button_sync.sv
// Two-flop synchronizer plus falling-edge detect for an active-low pedestrian button.
module ped_button_sync (
  input  logic clk_50_mhz,
  input  logic reset_n,
  input  logic button_n_i,
  output logic press_o
);

  logic meta_q, sync_q, prev_q;

  // Flops reset to the idle (released) level so leaving reset never looks like a press.
  always_ff @(posedge clk_50_mhz) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= button_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Phase sequencer for one intersection: vehicle lights, pedestrian walk/stop and request queues.
module intersection_phase_ctrl
  import tl_pkg::*;
#(
  parameter int TICK_DIV      = 50000000,
  parameter int GRN_TICKS     = 20,
  parameter int MIN_GRN_TICKS = 10,
  parameter int YLW_TICKS     = 3,
  parameter int ALLRED_TICKS  = 1,
  parameter int WALK_TICKS    = 7,
  parameter int CNT_W         = 8
) (
  input  logic clk_50_mhz,
  input  logic reset_n,
  input  logic nrth_ped_button,
  input  logic west_ped_button,
  output logic red_light_nrth_st,
  output logic ylw_light_nrth_st,
  output logic grn_light_nrth_st,
  output logic red_light_west_st,
  output logic ylw_light_west_st,
  output logic grn_light_west_st,
  output logic walk_light_nrth_st,
  output logic stop_light_nrth_st,
  output logic walk_light_west_st,
  output logic stop_light_west_st,
  output logic nrth_ped_q,
  output logic west_ped_q,
  output logic phase_strobe
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GRN_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_TICKS - 1);

  logic [PW-1:0]    presc_q;
  logic             tick;
  phase_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             nrth_ped_d, west_ped_d;
  logic             walk_n_q, walk_n_d, walk_w_q, walk_w_d;
  logic [2:0]       nrth_lt_q, west_lt_q;
  logic             nrth_press, west_press;
  logic             early, enter_ns, enter_we;

  ped_button_sync u_nrth_sync (
    .clk_50_mhz (clk_50_mhz),
    .reset_n    (reset_n),
    .button_n_i (nrth_ped_button),
    .press_o    (nrth_press)
  );

  ped_button_sync u_west_sync (
    .clk_50_mhz (clk_50_mhz),
    .reset_n    (reset_n),
    .button_n_i (west_ped_button),
    .press_o    (west_press)
  );

  function automatic logic [CNT_W-1:0] last_tick(input phase_e s);
    case (s)
      NS_GRN, WE_GRN: return CNT_W'(GRN_TICKS - 1);
      NS_YLW, WE_YLW: return CNT_W'(YLW_TICKS - 1);
      default:        return CNT_W'(ALLRED_TICKS - 1);
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e s);
    case (s)
      NS_GRN:  return NS_YLW;
      NS_YLW:  return AR_N;
      AR_N:    return WE_GRN;
      WE_GRN:  return WE_YLW;
      WE_YLW:  return AR_W;
      default: return NS_GRN;
    endcase
  endfunction

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    early   = ((state_q == NS_GRN) && west_ped_q) || ((state_q == WE_GRN) && nrth_ped_q);
    if (tick) begin
      if ((timer_q == last_tick(state_q)) || (early && (timer_q >= MIN_M1))) begin
        state_d = next_phase(state_q);
        timer_d = '0;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end
  end

  assign enter_ns = (state_d == NS_GRN) && (state_q != NS_GRN);
  assign enter_we = (state_d == WE_GRN) && (state_q != WE_GRN);

  // A pending request is served on green entry; a press landing on that same edge is the
  // pedestrian being served, so the clear takes priority over the new edge.
  always_comb begin
    nrth_ped_d = nrth_ped_q;
    walk_n_d   = walk_n_q;
    if (enter_ns && nrth_ped_q) begin
      nrth_ped_d = 1'b0;
      walk_n_d   = 1'b1;
    end else begin
      if (nrth_press) nrth_ped_d = 1'b1;
      if ((tick && (state_q == NS_GRN) && (timer_q == WALK_M1)) || (state_d != NS_GRN))
        walk_n_d = 1'b0;
    end
  end

  always_comb begin
    west_ped_d = west_ped_q;
    walk_w_d   = walk_w_q;
    if (enter_we && west_ped_q) begin
      west_ped_d = 1'b0;
      walk_w_d   = 1'b1;
    end else begin
      if (west_press) west_ped_d = 1'b1;
      if ((tick && (state_q == WE_GRN) && (timer_q == WALK_M1)) || (state_d != WE_GRN))
        walk_w_d = 1'b0;
    end
  end

  // Lights are decoded from the next state so they update on the same edge as state_q.
  always_ff @(posedge clk_50_mhz) begin
    if (!reset_n) begin
      presc_q      <= '0;
      state_q      <= AR_W;
      timer_q      <= '0;
      nrth_ped_q   <= 1'b0;
      west_ped_q   <= 1'b0;
      walk_n_q     <= 1'b0;
      walk_w_q     <= 1'b0;
      nrth_lt_q    <= nrth_lights(AR_W);
      west_lt_q    <= west_lights(AR_W);
      phase_strobe <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + PW'(1);
      state_q      <= state_d;
      timer_q      <= timer_d;
      nrth_ped_q   <= nrth_ped_d;
      west_ped_q   <= west_ped_d;
      walk_n_q     <= walk_n_d;
      walk_w_q     <= walk_w_d;
      nrth_lt_q    <= nrth_lights(state_d);
      west_lt_q    <= west_lights(state_d);
      phase_strobe <= (state_d != state_q);
    end
  end

  assign red_light_nrth_st  = nrth_lt_q[LT_RED];
  assign ylw_light_nrth_st  = nrth_lt_q[LT_YLW];
  assign grn_light_nrth_st  = nrth_lt_q[LT_GRN];
  assign red_light_west_st  = west_lt_q[LT_RED];
  assign ylw_light_west_st  = west_lt_q[LT_YLW];
  assign grn_light_west_st  = west_lt_q[LT_GRN];
  assign walk_light_nrth_st = walk_n_q;
  assign stop_light_nrth_st = ~walk_n_q;
  assign walk_light_west_st = walk_w_q;
  assign stop_light_west_st = ~walk_w_q;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed bench for intersection_phase_ctrl with TICK_DIV=4 (one tick every 4 clocks).
module tb_intersection_phase_ctrl;
  import tl_pkg::*;

  logic clk_50_mhz = 1'b0;
  logic reset_n = 1'b0;
  logic nrth_ped_button = 1'b1;
  logic west_ped_button = 1'b1;
  logic red_n, ylw_n, grn_n, red_w, ylw_w, grn_w;
  logic walk_n, stop_n, walk_w, stop_w;
  logic nrth_q, west_q, strobe;

  int tests = 0;
  int fails = 0;
  int dual_grn = 0;
  int stop_bad = 0;

  always #5 clk_50_mhz = ~clk_50_mhz;

  intersection_phase_ctrl #(.TICK_DIV(4)) dut (
    .clk_50_mhz         (clk_50_mhz),
    .reset_n            (reset_n),
    .nrth_ped_button    (nrth_ped_button),
    .west_ped_button    (west_ped_button),
    .red_light_nrth_st  (red_n),
    .ylw_light_nrth_st  (ylw_n),
    .grn_light_nrth_st  (grn_n),
    .red_light_west_st  (red_w),
    .ylw_light_west_st  (ylw_w),
    .grn_light_west_st  (grn_w),
    .walk_light_nrth_st (walk_n),
    .stop_light_nrth_st (stop_n),
    .walk_light_west_st (walk_w),
    .stop_light_west_st (stop_w),
    .nrth_ped_q         (nrth_q),
    .west_ped_q         (west_q),
    .phase_strobe       (strobe)
  );

  // {red,ylw,grn} north then west; {walk,stop} north then west.
  wire [5:0] lights = {red_n, ylw_n, grn_n, red_w, ylw_w, grn_w};
  wire [3:0] peds   = {walk_n, stop_n, walk_w, stop_w};

  always @(negedge clk_50_mhz) begin
    if (grn_n && grn_w) dual_grn++;
    if ((stop_n !== ~walk_n) || (stop_w !== ~walk_w)) stop_bad++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_50_mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held for three edges.
    step(3);
    chk("rst_lights", lights, 6'b100100);
    chk("rst_peds", peds, 4'b0101);
    chk("rst_queues", {nrth_q, west_q}, 2'b00);
    chk("rst_strobe", strobe, 1'b0);

    // Test 1: first tick after 4 clocks moves AR_W -> NS_GRN.
    reset_n = 1'b1;
    step(3);
    chk("t1_still_ar", lights, 6'b100100);
    chk("t1_no_strobe", strobe, 1'b0);
    step(1);
    chk("t1_ns_grn", lights, 6'b001100);
    chk("t1_strobe", strobe, 1'b1);
    step(1);
    chk("t1_strobe_once", strobe, 1'b0);

    // Test 2: undisturbed 80/12/4 clock phases.
    step(78);
    chk("t2_ns_grn_last", lights, 6'b001100);
    chk("t2_no_walk", peds, 4'b0101);
    step(1);
    chk("t2_ns_ylw", lights, 6'b010100);
    chk("t2_ylw_strobe", strobe, 1'b1);
    step(11);
    chk("t2_ns_ylw_last", lights, 6'b010100);
    step(1);
    chk("t2_ar_n", lights, 6'b100100);
    step(3);
    chk("t2_ar_n_last", lights, 6'b100100);
    step(1);
    chk("t2_we_grn", lights, 6'b100001);
    chk("t2_we_strobe", strobe, 1'b1);
    chk("t2_we_no_walk", peds, 4'b0101);

    // Test 3: north press in WE_GRN tick 2, early termination and north walk service.
    step(8);
    nrth_ped_button = 1'b0;
    step(1);
    nrth_ped_button = 1'b1;
    chk("t3_q_lat1", nrth_q, 1'b0);
    step(1);
    chk("t3_q_lat2", nrth_q, 1'b0);
    step(1);
    chk("t3_q_set", nrth_q, 1'b1);
    step(28);
    chk("t3_we_grn_t9", lights, 6'b100001);
    step(1);
    chk("t3_early_ylw", lights, 6'b100010);
    chk("t3_early_strobe", strobe, 1'b1);
    step(16);
    chk("t3_ns_entry", lights, 6'b001100);
    chk("t3_q_cleared", nrth_q, 1'b0);
    chk("t3_walk_on", peds, 4'b1001);
    step(27);
    chk("t3_walk_last", peds, 4'b1001);
    step(1);
    chk("t3_walk_off", peds, 4'b0101);

    // Test 4: west request, then a second press landing on WE_GRN entry.
    west_ped_button = 1'b0;
    step(1);
    west_ped_button = 1'b1;
    step(2);
    chk("t4_west_q", west_q, 1'b1);
    step(8);
    chk("t4_ns_grn_t9", lights, 6'b001100);
    step(1);
    chk("t4_ns_early", lights, 6'b010100);
    step(13);
    west_ped_button = 1'b0;
    step(1);
    west_ped_button = 1'b1;
    chk("t4_q_before", west_q, 1'b1);
    step(2);
    chk("t4_we_entry", lights, 6'b100001);
    chk("t4_clear_wins", west_q, 1'b0);
    chk("t4_walk_w", peds, 4'b0110);
    step(2);
    chk("t4_no_requeue", west_q, 1'b0);
    step(25);
    chk("t4_walk_last", peds, 4'b0110);
    step(1);
    chk("t4_walk_off", peds, 4'b0101);
    step(51);
    chk("t4_full_grn", lights, 6'b100001);
    step(1);
    chk("t4_we_ylw", lights, 6'b100010);

    // Test 5: north button held low for 100 clocks.
    nrth_ped_button = 1'b0;
    step(3);
    chk("t5_q_set", nrth_q, 1'b1);
    step(13);
    chk("t5_ns_entry", lights, 6'b001100);
    chk("t5_q_cleared", nrth_q, 1'b0);
    chk("t5_walk_on", peds, 4'b1001);
    step(54);
    chk("t5_held_single", nrth_q, 1'b0);
    step(30);
    nrth_ped_button = 1'b1;
    step(5);
    chk("t5_release", nrth_q, 1'b0);
    chk("t5_ns_ylw", lights, 6'b010100);
    step(7);
    chk("t5_we_grn", lights, 6'b100001);
    step(80);
    chk("t6_we_ylw", lights, 6'b100010);

    // Test 6: reset pulse in WE_YLW with both queues pending.
    nrth_ped_button = 1'b0;
    west_ped_button = 1'b0;
    step(1);
    nrth_ped_button = 1'b1;
    west_ped_button = 1'b1;
    step(2);
    chk("t6_both_q", {nrth_q, west_q}, 2'b11);
    step(2);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("t6_rst_lights", lights, 6'b100100);
    chk("t6_rst_peds", peds, 4'b0101);
    chk("t6_rst_queues", {nrth_q, west_q}, 2'b00);
    chk("t6_rst_strobe", strobe, 1'b0);
    step(3);
    chk("t6_restart_ar", lights, 6'b100100);
    step(1);
    chk("t6_restart_ns", lights, 6'b001100);
    chk("t6_restart_strobe", strobe, 1'b1);

    chk("dual_green", dual_grn, 0);
    chk("stop_not_walk", stop_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intersection_phase_ctrl.md
Name: intersection_phase_ctrl

Overview:
Per-intersection phase sequencer. It drives the north/west vehicle lights (red/ylw/grn) and the pedestrian walk/stop lights for one intersection; traffic_light_top instantiates it once for 10th and once for 11th street. Pedestrian button presses are queued and served in the next matching green phase. A pending cross-direction request shortens the current green once its minimum time has elapsed.

Parameters:
TICK_DIV, 50000000, clk_50_mhz cycles per timing tick (1 s at 50 MHz); simulation uses small values.
GRN_TICKS, 20, nominal green duration in ticks.
MIN_GRN_TICKS, 10, minimum green before early termination; must satisfy WALK_TICKS <= MIN_GRN_TICKS <= GRN_TICKS.
YLW_TICKS, 3, yellow duration.
ALLRED_TICKS, 1, all-red clearance duration.
WALK_TICKS, 7, walk-light duration at the start of a served green.
CNT_W, 8, phase timer width; every *_TICKS value must be < 2^CNT_W.

Ports:
clk_50_mhz  in  1  system clock, single clock domain
reset_n  in  1  synchronous, active-low reset
nrth_ped_button  in  1  asynchronous, active-low; a press is a 1->0 transition
west_ped_button  in  1  asynchronous, active-low
red_light_nrth_st / ylw_light_nrth_st / grn_light_nrth_st  out  1 each  north vehicle lights
red_light_west_st / ylw_light_west_st / grn_light_west_st  out  1 each  west vehicle lights
walk_light_nrth_st / stop_light_nrth_st  out  1 each  north crossing lights
walk_light_west_st / stop_light_west_st  out  1 each  west crossing lights
nrth_ped_q  out  1  north request pending (debug)
west_ped_q  out  1  west request pending (debug)
phase_strobe  out  1  one-cycle pulse on every state change

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=AR_W (all-red after west), phase timer=0, prescaler=0, both queues=0, phase_strobe=0.
  - Outputs: both reds=1, all ylw/grn=0, both walk=0, both stop=1.
- Reset mid-phase aborts immediately to the reset state. Lights must never show green on both directions.
- Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
- Button path:
  - 2-flop synchronizer, then falling-edge detect on the synchronized value.
  - Press to q=1 latency: 3 clocks.
  - A held-low button produces one request only.
- FSM states: NS_GRN -> NS_YLW -> AR_N -> WE_GRN -> WE_YLW -> AR_W -> NS_GRN.
  - State advances only on a tick cycle where timer==duration-1; the timer then clears to 0.
  - Otherwise the timer increments on each tick.
- Early termination in NS_GRN: if west_ped_q=1 and timer>=MIN_GRN_TICKS-1 on a tick, go to NS_YLW. WE_GRN mirrors this with nrth_ped_q.
- Service:
  - On the entry cycle into NS_GRN, if nrth_ped_q=1: clear it and set the north walk flag.
  - walk_light_nrth_st=1 for ticks 0..WALK_TICKS-1 of NS_GRN, then 0.
  - stop_light_nrth_st = ~walk_light_nrth_st at all times. West mirrors this.
- Simultaneous press and clear (press edge on the same cycle as entry clear for that direction): clear wins and q stays 0, since that pedestrian is served in this phase.
- A press during its own green after entry sets q and is served next cycle round.
- Light decode:
  - Moore, from the registered state; lights change in the same cycle the state register updates.
  - Exactly one of red/ylw/grn per direction is 1.
  - North is green/yellow only in NS_GRN/NS_YLW, else red; west likewise.
- phase_strobe is registered, high in the first cycle of each new state.

Decomposition:
- Shared package tl_pkg: state encoding localparams (3-bit: NS_GRN=0, NS_YLW=1, AR_N=2, WE_GRN=3, WE_YLW=4, AR_W=5) and light-bit index constants, reused by traffic_light_top and its bench.
- One sub-module, ped_button_sync (synchronizer + falling-edge detect, reset_n synchronous), instantiated twice.
- Prescaler, timer, FSM and queues stay in the parent.

Test Plan:
1. Reset release with TICK_DIV=4, defaults otherwise -> all reds and stops on. After 4 clocks (1 tick) enter NS_GRN: grn_light_nrth_st=1, red_light_west_st=1, phase_strobe pulses once.
2. No buttons -> full cycle durations of 20/3/1/20/3/1 ticks, i.e. 80/12/4/80/12/4 clocks. Walk lights never assert; both grn never high together.
3. nrth_ped_button low for 1 clock during WE_GRN tick 2 -> nrth_ped_q=1 after 3 clocks. WE_GRN ends at tick 10 (MIN_GRN). On NS_GRN entry q clears and walk_light_nrth_st=1 for 7 ticks, then stop=1.
4. west_ped_button pressed on the exact cycle of WE_GRN entry with west_ped_q already 1 -> q=0 after entry, walk_light_west_st on for 7 ticks, no second service.
5. Button held low for 100 clocks -> exactly one request latched.
6. reset_n=0 for 1 clock mid-WE_YLW with both queues set -> next cycle all red, stops on, queues 0, timer/prescaler 0; sequence restarts as in test 1.
